// File: rtl/izh_neuron_array.sv
// Time-multiplexed array of Izhikevich neurons sharing one fixed-point Euler
// datapath; spikes leave as indexed events over a valid/ready handshake.
module izh_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int V_WIDTH   = 16,
  parameter int FRAC      = 7,
  parameter int DT_SHIFT  = 4,
  localparam int IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [2:0]       cfg_sel,
  input  logic [7:0]       cfg_data,
  input  logic             step_start,
  output logic             busy,
  output logic             step_done,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  input  logic             spike_ready,
  input  logic [IDX_W-1:0] mon_sel,
  output logic [7:0]       membrane_out
);

  localparam int W2 = 2 * V_WIDTH + 4;
  localparam logic signed [W2-1:0] SAT_MAX = {{(W2 - V_WIDTH + 1){1'b0}}, {(V_WIDTH - 1){1'b1}}};
  localparam logic signed [W2-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [W2-1:0] K5      = W2'(5);
  localparam logic signed [W2-1:0] K140S   = W2'(140 * (2 ** FRAC));
  localparam logic signed [V_WIDTH-1:0] V_PEAK = V_WIDTH'(30 * (2 ** FRAC));
  localparam logic signed [V_WIDTH-1:0] V_REST = V_WIDTH'(-70 * (2 ** FRAC));
  localparam logic signed [V_WIDTH+1:0] MEM_OFS = (V_WIDTH + 2)'(70);
  localparam logic signed [V_WIDTH+1:0] MEM_MAX = (V_WIDTH + 2)'(255);
  localparam logic [IDX_W:0]   N_L      = (IDX_W + 1)'(N_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CALC, S_WB, S_EMIT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic signed [V_WIDTH-1:0] v_mem [N_NEURONS];
  logic signed [V_WIDTH-1:0] u_mem [N_NEURONS];
  logic [7:0]                a_mem [N_NEURONS];
  logic [7:0]                b_mem [N_NEURONS];
  logic signed [7:0]         c_mem [N_NEURONS];
  logic [7:0]                d_mem [N_NEURONS];
  logic [7:0]                stim_mem [N_NEURONS];

  logic [IDX_W-1:0]          idx;
  logic signed [V_WIDTH-1:0] v_r, u_r, v_nx_r, u_nx_r;
  logic [7:0]                a_r, b_r, d_r, stim_r;
  logic signed [7:0]         c_r;

  logic signed [W2-1:0]      v_s, u_s, a_s, b_s, d_s, stim_s;
  logic signed [W2-1:0]      dv_full, bv_term, du_full;
  logic signed [V_WIDTH-1:0] dv_sat, du_sat, v_nx, u_nx, v_spk, u_spk;
  logic                      spike, last;

  logic signed [V_WIDTH-1:0] v_mon;
  logic signed [V_WIDTH+1:0] mon_ext, mem_lvl;

  function automatic logic signed [V_WIDTH-1:0] sat(input logic signed [W2-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[V_WIDTH-1:0];
    else if (x < SAT_MIN) return SAT_MIN[V_WIDTH-1:0];
    else                  return x[V_WIDTH-1:0];
  endfunction

  // Shared Euler datapath, evaluated on the operands latched in LOAD.
  always_comb begin
    v_s     = W2'(v_r);
    u_s     = W2'(u_r);
    a_s     = W2'($signed({1'b0, a_r}));
    b_s     = W2'($signed({1'b0, b_r}));
    d_s     = W2'($signed({1'b0, d_r}));
    stim_s  = W2'($signed({1'b0, stim_r}));
    dv_full = ((K5 * v_s * v_s) >>> (FRAC + 7)) + K5 * v_s + K140S + (stim_s <<< FRAC) - u_s;
    dv_sat  = sat(dv_full);
    bv_term = (b_s * v_s) >>> 8;
    du_full = (a_s * (bv_term - u_s)) >>> 8;
    du_sat  = sat(du_full);
    v_nx    = sat(v_s + (W2'(dv_sat) >>> DT_SHIFT));
    u_nx    = sat(u_s + (W2'(du_sat) >>> DT_SHIFT));
    spike   = (v_nx_r >= V_PEAK);
    v_spk   = V_WIDTH'(c_r) <<< FRAC;
    u_spk   = sat(W2'(u_nx_r) + (d_s <<< FRAC));
    last    = (idx == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else if (enable) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (step_start) state_nx = S_LOAD;
      S_LOAD: state_nx = S_CALC;
      S_CALC: state_nx = S_WB;
      S_WB: begin
        if (spike)     state_nx = S_EMIT;
        else if (last) state_nx = S_DONE;
        else           state_nx = S_LOAD;
      end
      S_EMIT: if (spike_ready) state_nx = last ? S_DONE : S_LOAD;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE);
    step_done   = (state == S_DONE);
    spike_valid = (state == S_EMIT);
    spike_idx   = spike_valid ? idx : '0;
  end

  // Configuration is only writable between steps, so a step never sees a
  // half-updated parameter set.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i]    <= V_REST;
        u_mem[i]    <= '0;
        a_mem[i]    <= 8'd5;
        b_mem[i]    <= 8'd51;
        c_mem[i]    <= -8'sd65;
        d_mem[i]    <= 8'd8;
        stim_mem[i] <= '0;
      end
      idx    <= '0;
      v_r    <= '0;
      u_r    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      c_r    <= '0;
      d_r    <= '0;
      stim_r <= '0;
      v_nx_r <= '0;
      u_nx_r <= '0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          if (cfg_we && ({1'b0, cfg_addr} < N_L)) begin
            case (cfg_sel)
              3'd0: a_mem[cfg_addr]    <= cfg_data;
              3'd1: b_mem[cfg_addr]    <= cfg_data;
              3'd2: c_mem[cfg_addr]    <= $signed(cfg_data);
              3'd3: d_mem[cfg_addr]    <= cfg_data;
              3'd4: stim_mem[cfg_addr] <= cfg_data;
              default: ;
            endcase
          end
          if (step_start) idx <= '0;
        end
        S_LOAD: begin
          v_r    <= v_mem[idx];
          u_r    <= u_mem[idx];
          a_r    <= a_mem[idx];
          b_r    <= b_mem[idx];
          c_r    <= c_mem[idx];
          d_r    <= d_mem[idx];
          stim_r <= stim_mem[idx];
        end
        S_CALC: begin
          v_nx_r <= v_nx;
          u_nx_r <= u_nx;
        end
        S_WB: begin
          v_mem[idx] <= spike ? v_spk : v_nx_r;
          u_mem[idx] <= spike ? u_spk : u_nx_r;
          if (!spike && !last) idx <= idx + 1'b1;
        end
        S_EMIT: if (spike_ready && !last) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    v_mon = V_REST;
    if ({1'b0, mon_sel} < N_L) v_mon = v_mem[mon_sel];
    mon_ext = (V_WIDTH + 2)'(v_mon >>> FRAC);
    mem_lvl = (mon_ext + MEM_OFS) <<< 1;
    if (mem_lvl[V_WIDTH+1])      membrane_out = 8'd0;
    else if (mem_lvl > MEM_MAX)  membrane_out = 8'd255;
    else                         membrane_out = mem_lvl[7:0];
  end

endmodule

// File: doc/izh_neuron_array.md
# izh_neuron_array

Time-multiplexed array of `N_NEURONS` Izhikevich neurons that share one fixed-point datapath. Per-neuron state, parameters and stimulus live in internal register files. One `step_start` pulse advances every neuron by one Euler step in index order. Spikes leave as indexed events over a valid/ready handshake to the downstream spike router. The block is the parametrised successor of the single-neuron core, adding neuron count, datapath width and back-pressure.

## Interface
- `N_NEURONS`, default 4: neurons in the array, range 1..64; `IDX_W = max(1, clog2(N_NEURONS))`.
- `V_WIDTH`, default 16: signed width of stored `v` and `u`; must be ≥ `FRAC + 9`.
- `FRAC`, default 7: fractional bits; `S = 2^FRAC`.
- `DT_SHIFT`, default 4: Euler step is the derivative arithmetically shifted right by `DT_SHIFT`.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: when low, the FSM and all state hold; no writes are accepted.
- `cfg_we`, in, 1: configuration write strobe.
- `cfg_addr`, in, `IDX_W`: target neuron.
- `cfg_sel`, in, 3: 0 = a, 1 = b, 2 = c, 3 = d, 4 = stimulus; 5..7 are ignored.
- `cfg_data`, in, 8: value written. `a`, `b`, `d` and stimulus are unsigned; `c` is signed mV.
- `step_start`, in, 1: starts one step over all neurons.
- `busy`, out, 1: high from the cycle after an accepted start until `step_done`, inclusive.
- `step_done`, out, 1: one-cycle pulse at the end of the step.
- `spike_valid`, out, 1: spike event pending.
- `spike_idx`, out, `IDX_W`: index of the spiking neuron.
- `spike_ready`, in, 1: downstream accepts the event.
- `mon_sel`, in, `IDX_W`: neuron selected for monitoring.
- `membrane_out`, out, 8: `clamp(((v[mon_sel] >>> FRAC) + 70) * 2, 0, 255)`, combinational from stored `v`.

## Operation
- **Reset values:**
  - every `v = -70*S`, every `u = 0`, every stimulus = 0;
  - a = 5, b = 51, c = -65, d = 8;
  - FSM in IDLE;
  - `busy`, `step_done` and `spike_valid` low, `spike_idx` = 0.
- **Config writes:** accepted only when `enable` is high and `busy` is low; otherwise dropped. A write with `cfg_addr ≥ N_NEURONS` is ignored.
- **FSM states:** IDLE, LOAD, CALC, WB, EMIT, DONE.
  - IDLE → LOAD on `step_start && enable`; `idx` = 0.
  - LOAD: register v, u, a, b, c, d and stimulus of neuron `idx`.
  - CALC: register `v_nx` and `u_nx`, using the arithmetic below.
  - WB: write `v`/`u`. If `spike` is set, go to EMIT. Otherwise go to LOAD with `idx+1`, or to DONE when `idx = N_NEURONS-1`.
  - EMIT: hold `spike_valid = 1` and `spike_idx = idx` until `spike_ready` is sampled high, then continue as WB would.
  - DONE: pulse `step_done`, then return to IDLE.
- **Arithmetic:** all intermediates are signed, width `2*V_WIDTH + 4`; every `>>>` is an arithmetic (floor) shift.
  - `dv = ((5*v*v) >>> (FRAC+7)) + 5*v + 140*S + (stim << FRAC) - u`, then saturate to the `V_WIDTH` signed range.
  - `du = (a * (((b*v) >>> 8) - u)) >>> 8`, then saturate to `V_WIDTH`.
  - `v_nx = sat(v + (dv >>> DT_SHIFT))` and `u_nx = sat(u + (du >>> DT_SHIFT))`.
  - `spike = (v_nx >= 30*S)`.
  - On spike, write `v = c << FRAC` (sign-extended) and `u = sat(u_nx + (d << FRAC))`.
- **Saturation bounds:** `-2^(V_WIDTH-1)` and `2^(V_WIDTH-1) - 1`.
- **Stimulus:** persists across steps until it is rewritten.

## Timing
- Step latency with no spikes: `3*N_NEURONS + 1` cycles from the accepted `step_start` to the `step_done` cycle, inclusive of DONE.
- Each spike adds at least 1 EMIT cycle, plus 1 cycle per cycle that `spike_ready` stays low.
- `spike_valid` rises the cycle after WB. It is deasserted the cycle after the handshake. `spike_idx` is stable while valid is high.
- `step_start` while `busy` is ignored; the block does not queue it.
- `enable` low mid-step freezes the FSM and all registers, including `spike_valid`. The step resumes exactly where it stopped.
- `reset` mid-step, including during EMIT, returns every output and all state to the reset values on the next edge. The pending event is lost.
- `membrane_out` reflects a WB write on the cycle after WB.

## Test plan
- **Rest step:** reset, pulse `step_start` with all stimulus 0 and default parameters, N = 4 → `step_done` exactly 13 cycles later. Every neuron has `v = -9109` and `u = -3`, and `membrane_out` = 0.
- **Spike and reset:** write stimulus 255 to neuron 2, then pulse a step repeatedly with `spike_ready` = 1 → `spike_valid` with `spike_idx` = 2 within 10 steps. The following cycle, `membrane_out` (`mon_sel` = 2) = 10 and `u[2]` includes +1024. No events come from neurons 0, 1 or 3.
- **Back-pressure:** hold `spike_ready` = 0 for 5 cycles during the spike → `spike_valid` and `spike_idx` stay stable and the step stretches by 5 cycles. `step_done` still pulses once.
- **Gating:** a config write while `busy` is dropped, verified by readback via the next step's result. `step_start` while `busy` is ignored. `enable` low for 3 cycles mid-step delays `step_done` by 3 cycles with identical results.
- **Reset mid-EMIT:** all outputs low or 0 next cycle. The next step reproduces the rest-step values.
- **Saturation:** `c` = 127, `d` = 255 with repeated spikes → `u` clamps at 32767 and `v` never wraps sign.
